back_ground_layers: RTL

- Parametrised, layered background renderer for the Gold Miner VGA path. Produces the per-pixel background colour and region-request flags from the current scan coordinates.
- Layers, in priority order: frame border, sky with horizontally scrolling cloud band, striped underground.
- Per-frame state:
  - cloud scroll offset, advanced once per frame;
  - border-flash state machine for game events such as time warning or level end.
- Output feeds the object mux as the lowest-priority layer.

---
 rtl/bg_pkg.sv | 23 ++
 rtl/bg_flash_fsm.sv | 89 ++++++++
 rtl/back_ground_layers.sv | 137 +++++++++++++
 3 files changed

// File: rtl/bg_pkg.sv
// Shared colours, ground palettes and flash-state encoding for the layered background.
package bg_pkg;

    localparam logic [7:0] BORDER_COLOR = 8'hE3;
    localparam logic [7:0] FLASH_COLOR  = 8'hFC;
    localparam logic [7:0] SKY_COLOR    = 8'h1F;
    localparam logic [7:0] CLOUD_COLOR  = 8'hFF;

    // Indexed [levelSel][stripe index]; one row per level.
    localparam logic [7:0] GROUND_PAL [0:3][0:3] = '{
        '{8'h8C, 8'h88, 8'h6C, 8'h68},
        '{8'hB0, 8'h90, 8'hAC, 8'h8C},
        '{8'h49, 8'h6D, 8'h25, 8'h92},
        '{8'hE0, 8'hC4, 8'hA0, 8'h80}
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } flash_state_t;

endpackage

// File: rtl/bg_flash_fsm.sv
// Border-flash burst sequencer: NUM_FLASHES ON/OFF pairs, each phase FLASH_FRAMES frames long.
module bg_flash_fsm
    import bg_pkg::*;
#(
    parameter int FLASH_FRAMES = 8,
    parameter int NUM_FLASHES  = 3
) (
    input  logic clk,
    input  logic resetN,
    input  logic startOfFrame,
    input  logic flashStart,
    output logic flashOn,
    output logic flashBusy
);

    localparam int FW = $clog2(FLASH_FRAMES + 1);
    localparam int PW = $clog2(NUM_FLASHES + 1);

    flash_state_t  state_q, state_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [PW-1:0] pair_q, pair_d;
    logic [PW-1:0] pair_inc;
    logic          busy_q;

    assign pair_inc = pair_q + PW'(1);

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        pair_d  = pair_q;
        // A start pulse always wins, even over a coincident frame tick.
        if (flashStart) begin
            state_d = ON;
            frame_d = '0;
            pair_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    frame_d = '0;
                    pair_d  = '0;
                end
                ON: begin
                    if (startOfFrame) begin
                        if (frame_q == FW'(FLASH_FRAMES - 1)) begin
                            state_d = OFF;
                            frame_d = '0;
                        end else begin
                            frame_d = frame_q + FW'(1);
                        end
                    end
                end
                OFF: begin
                    if (startOfFrame) begin
                        if (frame_q == FW'(FLASH_FRAMES - 1)) begin
                            pair_d  = pair_inc;
                            frame_d = '0;
                            state_d = (pair_inc == PW'(NUM_FLASHES)) ? IDLE : ON;
                        end else begin
                            frame_d = frame_q + FW'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    frame_d = '0;
                    pair_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            frame_q <= '0;
            pair_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            pair_q  <= pair_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign flashOn   = (state_q == ON);
    assign flashBusy = busy_q;

endmodule

// File: rtl/back_ground_layers.sv
// Lowest-priority VGA layer: border, sky with scrolling cloud band, and striped ground,
// all registered one clock after the scan coordinates.
module back_ground_layers
    import bg_pkg::*;
#(
    parameter int H_ACTIVE          = 640,
    parameter int V_ACTIVE          = 480,
    parameter int BORDER_W          = 20,
    parameter int SKY_H             = 120,
    parameter int CLOUD_Y0          = 40,
    parameter int CLOUD_H           = 24,
    parameter int CLOUD_PERIOD_LOG2 = 6,
    parameter int SCROLL_STEP       = 2,
    parameter int STRIPE_LOG2       = 5,
    parameter int FLASH_FRAMES      = 8,
    parameter int NUM_FLASHES       = 3
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        startOfFrame,
    input  logic        scrollEn,
    input  logic [1:0]  levelSel,
    input  logic        flashStart,
    output logic [7:0]  BG_RGB,
    output logic        boardersDrawReq,
    output logic        skyDrawReq,
    output logic        flashBusy
);

    if (!(2 * BORDER_W < V_ACTIVE)) begin : g_bad_border
        $error("BORDER_W too large for V_ACTIVE");
    end
    if (!(SKY_H < V_ACTIVE)) begin : g_bad_sky
        $error("SKY_H must be below V_ACTIVE");
    end
    if (!(CLOUD_Y0 + CLOUD_H <= SKY_H)) begin : g_bad_cloud
        $error("cloud band must lie inside the sky");
    end
    if (!(SCROLL_STEP < H_ACTIVE)) begin : g_bad_step
        $error("SCROLL_STEP must be below H_ACTIVE");
    end

    localparam int SW  = $clog2(H_ACTIVE);
    localparam int SW1 = SW + 1;

    localparam logic [10:0] X_END   = 11'(H_ACTIVE);
    localparam logic [10:0] Y_END   = 11'(V_ACTIVE);
    localparam logic [10:0] BW      = 11'(BORDER_W);
    localparam logic [10:0] X_RB    = 11'(H_ACTIVE - BORDER_W);
    localparam logic [10:0] Y_BB    = 11'(V_ACTIVE - BORDER_W);
    localparam logic [10:0] SKY_END = 11'(SKY_H);
    localparam logic [10:0] CY_LO   = 11'(CLOUD_Y0);
    localparam logic [10:0] CY_HI   = 11'(CLOUD_Y0 + CLOUD_H);

    logic          flash_on;
    logic [SW-1:0] scroll_q, scroll_d;
    logic [SW:0]   scroll_sum;
    logic [11:0]   xs_sum, xs;
    logic          cloud_bit;
    logic [1:0]    stripe_idx;
    logic          outside, in_border, in_cloud_rows;
    logic [7:0]    rgb_q, rgb_d;
    logic          border_q, border_d;
    logic          sky_q, sky_d;

    bg_flash_fsm #(
        .FLASH_FRAMES (FLASH_FRAMES),
        .NUM_FLASHES  (NUM_FLASHES)
    ) u_flash (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .flashStart   (flashStart),
        .flashOn      (flash_on),
        .flashBusy    (flashBusy)
    );

    // Single-subtract wrap keeps the offset in [0, H_ACTIVE-1] since SCROLL_STEP < H_ACTIVE.
    always_comb begin
        scroll_sum = {1'b0, scroll_q} + SW1'(SCROLL_STEP);
        scroll_d   = scroll_q;
        if (startOfFrame && scrollEn) begin
            if (scroll_sum >= SW1'(H_ACTIVE)) begin
                scroll_d = SW'(scroll_sum - SW1'(H_ACTIVE));
            end else begin
                scroll_d = SW'(scroll_sum);
            end
        end
    end

    assign xs_sum     = {1'b0, pixelX} + 12'(scroll_q);
    assign xs         = (xs_sum >= 12'(H_ACTIVE)) ? (xs_sum - 12'(H_ACTIVE)) : xs_sum;
    assign cloud_bit  = 1'(xs >> (CLOUD_PERIOD_LOG2 - 1));
    assign stripe_idx = 2'((pixelY - SKY_END) >> STRIPE_LOG2);

    assign outside       = (pixelX >= X_END) || (pixelY >= Y_END);
    assign in_border     = (pixelX < BW) || (pixelY < BW) || (pixelX >= X_RB) || (pixelY >= Y_BB);
    assign in_cloud_rows = (pixelY >= CY_LO) && (pixelY < CY_HI);

    always_comb begin
        rgb_d    = 8'h00;
        border_d = 1'b0;
        sky_d    = 1'b0;
        if (!outside) begin
            if (in_border) begin
                border_d = 1'b1;
                rgb_d    = flash_on ? FLASH_COLOR : BORDER_COLOR;
            end else if (pixelY < SKY_END) begin
                sky_d = 1'b1;
                rgb_d = (in_cloud_rows && cloud_bit) ? CLOUD_COLOR : SKY_COLOR;
            end else begin
                rgb_d = GROUND_PAL[levelSel][stripe_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            scroll_q <= '0;
            rgb_q    <= 8'h00;
            border_q <= 1'b0;
            sky_q    <= 1'b0;
        end else begin
            scroll_q <= scroll_d;
            rgb_q    <= rgb_d;
            border_q <= border_d;
            sky_q    <= sky_d;
        end
    end

    assign BG_RGB          = rgb_q;
    assign boardersDrawReq = border_q;
    assign skyDrawReq      = sky_q;

endmodule
